// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the downstream load filter:
// func3 codes, FSM states and the access-size helper.
package lsu_pkg;

    localparam int STRB_W = 8;

    localparam logic [2:0] F3_B       = 3'b000;
    localparam logic [2:0] F3_H       = 3'b001;
    localparam logic [2:0] F3_W       = 3'b010;
    localparam logic [2:0] F3_D       = 3'b011;
    localparam logic [2:0] F3_BU      = 3'b100;
    localparam logic [2:0] F3_HU      = 3'b101;
    localparam logic [2:0] F3_WU      = 3'b110;
    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] lsuSize(input logic [1:0] sizeCode);
        return 4'd1 << sizeCode;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for one memory beat: shifts store data/strobes into
// their lanes and extracts the right-aligned slice of a load beat.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        off_i,
    input  logic [3:0]        size_i,
    input  logic              beat_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   ldata_o
);

    logic [5:0]  shiftLo;
    logic [6:0]  shiftHi;
    logic [7:0]  sizeMask;
    logic [15:0] strbFull;

    // The upper half of strbFull holds the lanes that spill into the next word.
    always_comb begin
        shiftLo  = {off_i, 3'b000};
        shiftHi  = 7'd64 - {1'b0, off_i, 3'b000};
        sizeMask = 8'((9'd1 << size_i) - 9'd1);
        strbFull = {8'b0, sizeMask} << off_i;
        if (beat_i) begin
            wdata_o = wdata_i >> shiftHi;
            wstrb_o = strbFull[15:8];
            ldata_o = rdata_i << shiftHi;
        end else begin
            wdata_o = wdata_i << shiftLo;
            wstrb_o = strbFull[7:0];
            ldata_o = rdata_i >> shiftLo;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64I memory-access stage: one request at a time, up to two aligned beats.
// Define LSU_MISALIGN_SPLIT_EN to perform misaligned accesses instead of faulting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [2:0]        rsp_func3,
    output logic [XLEN-1:0]   rsp_ldata,
    output logic              rsp_err
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   ldata_q, ldata_d;
    logic              rspValid_q, rspValid_d;
    logic              rspErr_q, rspErr_d;
    logic [2:0]        rspFunc3_q, rspFunc3_d;
    logic [XLEN-1:0]   rspLdata_q, rspLdata_d;

    logic [3:0]        size;
    logic              crossing;
    logic              reqErr;
    logic [XLEN-1:0]   loadMask;
    logic [XLEN-1:0]   alignWdata;
    logic [STRB_W-1:0] alignStrb;
    logic [XLEN-1:0]   alignLdata;
    logic              finish;
    logic [XLEN-1:0]   loadResult;

    lsu_align #(.XLEN(XLEN)) u_align (
        .off_i   (addr_q[2:0]),
        .size_i  (size),
        .beat_i  (state_q == BEAT1),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .wdata_o (alignWdata),
        .wstrb_o (alignStrb),
        .ldata_o (alignLdata)
    );

    always_comb begin
        size     = lsuSize(func3_q[1:0]);
        crossing = ({1'b0, addr_q[2:0]} + size) > 4'd8;
        loadMask = '0;
        for (int i = 0; i < 8; i++) begin
            loadMask[8*i +: 8] = (4'(i) < size) ? 8'hFF : 8'h00;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign reqErr = (req_func3 == F3_ILLEGAL) || (req_we && req_func3[2]);
`else
    logic [3:0] reqSize;
    assign reqSize = lsuSize(req_func3[1:0]);
    assign reqErr  = (req_func3 == F3_ILLEGAL) || (req_we && req_func3[2])
                   || ((req_addr[2:0] & 3'(reqSize - 4'd1)) != 3'b000);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            func3_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ldata_q    <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspFunc3_q <= '0;
            rspLdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            func3_q    <= func3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ldata_q    <= ldata_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspFunc3_q <= rspFunc3_d;
            rspLdata_q <= rspLdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        func3_d    = func3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        rspValid_d = 1'b0;
        rspErr_d   = rspErr_q;
        rspFunc3_d = rspFunc3_q;
        rspLdata_d = rspLdata_q;
        finish     = 1'b0;
        loadResult = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    ldata_d = '0;
                    if (reqErr) begin
                        state_d    = RESP;
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspFunc3_d = req_func3;
                        rspLdata_d = '0;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (crossing) begin
                        state_d = BEAT1;
                        ldata_d = alignLdata;
                    end else begin
                        finish     = 1'b1;
                        loadResult = alignLdata;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    finish     = 1'b1;
                    loadResult = ldata_q | alignLdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Successful completion of the final beat registers the response.
        if (finish) begin
            state_d    = RESP;
            rspValid_d = 1'b1;
            rspErr_d   = 1'b0;
            rspFunc3_d = func3_q;
            rspLdata_d = we_q ? '0 : (loadResult & loadMask);
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && rst_n;
        mem_req   = (state_q == BEAT0) || (state_q == BEAT1);
        mem_we    = mem_req && we_q;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr = {addr_q[XLEN-1:3], 3'b000} + ((state_q == BEAT1) ? XLEN'(8) : XLEN'(0));
        end
        if (mem_we) begin
            mem_wstrb = alignStrb;
            mem_wdata = alignWdata;
        end
        rsp_valid = rspValid_q;
        rsp_err   = rspErr_q;
        rsp_func3 = rspFunc3_q;
        rsp_ldata = rspLdata_q;
    end

endmodule
